// File: rtl/mysystem_ram_bist_if.sv
// Avalon-MM bus between the RAM BIST master and the on-chip RAM s1 port.
// Master drives address/control/write data; slave returns read data one cycle later.
// No waitrequest: the RAM accepts one access per cycle unconditionally.
interface mysystem_ram_bist_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_clken;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_write,
           avm_writedata, avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_write,
           avm_writedata, avm_clken,
    output avm_readdata
  );
endinterface

// File: rtl/mysystem_ram_bist.sv
// RAM self test: writes pat(a)=seed+a to every word, reads back, counts mismatches.
// Latency: start accepted at edge T -> done high in the cycle captured at edge T+2*DEPTH+2.
// Backpressure: none; the RAM takes one access per cycle, start is ignored while busy.
module mysystem_ram_bist #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  mysystem_ram_bist_if.master avm
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic              cmp_vld_q;
  logic              first_seen_q;
  logic              accept;
  logic              mismatch;

  // Pattern word for the current address; the address is zero-extended.
  assign pat      = seed_q + DATA_W'(addr_q);
  assign accept   = (state_q == S_IDLE) && start;
  // Read data for the previous READ cycle is on avm_readdata now.
  assign mismatch = cmp_vld_q && (avm.avm_readdata != exp_q);

  // State and address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; the address only wraps by leaving WRITE or READ.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (start) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Outputs decoded from state; everything is zero outside an active access.
  always_comb begin
    busy               = 1'b0;
    done               = 1'b0;
    avm.avm_address    = '0;
    avm.avm_chipselect = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_writedata  = '0;
    avm.avm_byteenable = '1;
    avm.avm_clken      = 1'b1;
    case (state_q)
      S_WRITE: begin
        busy               = 1'b1;
        avm.avm_address    = addr_q;
        avm.avm_chipselect = 1'b1;
        avm.avm_write      = 1'b1;
        avm.avm_writedata  = pat;
      end
      S_READ: begin
        busy               = 1'b1;
        avm.avm_address    = addr_q;
        avm.avm_chipselect = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Compare pipeline: expected word and address follow each read by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_vld_q  <= 1'b0;
      exp_q      <= '0;
      cmp_addr_q <= '0;
    end else begin
      cmp_vld_q  <= (state_q == S_READ);
      exp_q      <= pat;
      cmp_addr_q <= addr_q;
    end
  end

  // Result registers: cleared on accepted start, updated on each mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_seen_q   <= 1'b0;
      pass           <= 1'b0;
    end else if (accept) begin
      seed_q         <= seed;
      err_count      <= '0;
      first_err_addr <= '0;
      first_seen_q   <= 1'b0;
      pass           <= 1'b0;
    end else begin
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!first_seen_q) begin
          first_err_addr <= cmp_addr_q;
          first_seen_q   <= 1'b1;
        end
      end
      // DRAIN carries the final compare, so fold it in when settling pass.
      if (state_q == S_DRAIN) pass <= (err_count == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_mysystem_ram_bist.sv
// Bench: RAM model with 1-cycle read latency and per-word fault masks,
// randomized seeds/faults, results checked against a pattern-level model.
module tb_mysystem_ram_bist;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int EW    = 4;
  localparam int LAT   = 2 * DEPTH + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] seed = '0;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  mysystem_ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) avm_bus ();

  mysystem_ram_bist #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .ERR_W(EW)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (avm_bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: read data = (stored ^ flip) | set1, one cycle after the read.
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] flip [DEPTH];
  logic [DW-1:0] set1 [DEPTH];
  logic [DW-1:0] rd_q = '0;
  int            addr_bad = 0;
  int            done_cnt = 0;

  assign avm_bus.avm_readdata = rd_q;

  always @(posedge clk) begin
    if (avm_bus.avm_chipselect) begin
      if (int'(avm_bus.avm_address) >= DEPTH)
        addr_bad <= addr_bad + 1;
      else if (avm_bus.avm_write)
        mem[int'(avm_bus.avm_address)] <= avm_bus.avm_writedata;
      else
        rd_q <= (mem[int'(avm_bus.avm_address)] ^ flip[int'(avm_bus.avm_address)])
                | set1[int'(avm_bus.avm_address)];
    end
  end

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) begin
      flip[a] = '0;
      set1[a] = '0;
    end
  endtask

  // Start a test (accepted at the next edge) and return the index of the edge
  // that captures done, counting the accepting edge as 0.
  task automatic run_test(input logic [DW-1:0] s, input bit hold, output int lat);
    lat = -1;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      @(negedge clk);
      if (!hold && i == 0) start = 1'b0;
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 64'(lat), 64'(LAT));
  endtask

  // Reference: every word should hold seed+a; a mismatch is any word whose
  // faulted read value differs from its pattern.
  task automatic verify(input string tag, input logic [DW-1:0] s, input int lat);
    int            cnt, first, bad;
    logic [DW-1:0] p;
    cnt = 0; first = 0; bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      p = s + DW'(a);
      if (((p ^ flip[a]) | set1[a]) != p) begin
        if (cnt == 0) first = a;
        cnt++;
      end
      if (mem[a] !== p) bad++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_err"}, 64'(err_count), 64'((cnt > 15) ? 15 : cnt));
    chk({tag, "_first"}, 64'(first_err_addr), 64'(first));
    chk({tag, "_pass"}, 64'(pass), 64'(cnt == 0));
    chk({tag, "_mem"}, 64'(bad), 64'd0);
  endtask

  function automatic logic [63:0] out_vec();
    return {busy, done, pass, err_count, first_err_addr, avm_bus.avm_address,
            avm_bus.avm_chipselect, avm_bus.avm_write, avm_bus.avm_writedata};
  endfunction

  initial begin
    int            lat, d0, a;
    logic [DW-1:0] s;
    logic [63:0]   snap;
    bit            found;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    clear_faults();

    // Reset state
    #12;
    @(negedge clk);
    chk("reset_outputs", out_vec(), 64'd0);
    chk("static_be_clken", {avm_bus.avm_byteenable, avm_bus.avm_clken}, 64'h1F);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean run
    run_test(32'h1000_0000, 1'b0, lat);
    verify("clean", 32'h1000_0000, lat);
    chk("clean_mem15", 64'(mem[15]), 64'h1000_000F);

    // Results stay stable in IDLE
    snap = {pass, err_count, first_err_addr};
    repeat (5) @(negedge clk);
    chk("idle_stable", {pass, err_count, first_err_addr}, snap);
    chk("idle_busy", 64'(busy), 64'd0);

    // Bit 0 forced to 1 at addresses 6 and 9, seed 0
    set1[6] = 32'h1;
    set1[9] = 32'h1;
    run_test(32'h0, 1'b0, lat);
    verify("stuck", 32'h0, lat);
    clear_faults();

    // Every word corrupted -> saturating counter
    for (int i = 0; i < DEPTH; i++) flip[i] = 32'h8000_0000;
    run_test($urandom, 1'b0, lat);
    chk("sat_err", 64'(err_count), 64'hF);
    chk("sat_pass", 64'(pass), 64'd0);
    chk("sat_first", 64'(first_err_addr), 64'd0);
    clear_faults();

    // Seed wrap: pattern passes through zero at address 8
    run_test(32'hFFFF_FFF8, 1'b0, lat);
    verify("wrap", 32'hFFFF_FFF8, lat);
    chk("wrap_mem8", 64'(mem[8]), 64'd0);

    // Random seeds and random fault masks
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ($urandom_range(3) == 0) flip[i] = 32'h1 << $urandom_range(31);
        if ($urandom_range(5) == 0) set1[i] = 32'h1 << $urandom_range(31);
      end
      s = $urandom;
      run_test(s, 1'b0, lat);
      verify("rand", s, lat);
      clear_faults();
    end

    // Reset mid-test during READ at address 5
    @(negedge clk);
    seed  = 32'h5555_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (avm_bus.avm_chipselect && !avm_bus.avm_write && avm_bus.avm_address == 5) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_read5", 64'(found), 64'd1);
    d0 = done_cnt;
    #1 reset_n = 1'b0;
    #1 chk("abort_outputs", out_vec(), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3 * DEPTH) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_test(32'hCAFE_0000, 1'b0, lat);
    verify("after_abort", 32'hCAFE_0000, lat);

    // start pulsed while busy is ignored
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    fork
      run_test(32'h0BAD_F00D, 1'b0, lat);
      begin
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    verify("busy_start", 32'h0BAD_F00D, lat);
    repeat (4) @(negedge clk);
    chk("busy_one_done", 64'(done_cnt - d0), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);

    // start held high: back-to-back tests
    d0 = done_cnt;
    for (int t = 0; t < 3; t++) begin
      s = $urandom;
      a = $urandom_range(DEPTH - 1);
      flip[a] = 32'h0000_0100;
      run_test(s, 1'b1, lat);
      if (t == 2) start = 1'b0;
      verify("held", s, lat);
      clear_faults();
    end
    repeat (4) @(negedge clk);
    chk("held_done_cnt", 64'(done_cnt - d0), 64'd3);

    chk("addr_range", 64'(addr_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
